rm_bist_march_ctrl: RTL and testbench

RM_BIST_MARCH_CTRL -- requirements
Module: rm_bist_march_ctrl

---
 rtl/rm_bist_march_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_rm_bist_march_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rm_bist_march_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rm_bist_march_ctrl
// Purpose  : March C- BIST sequencer for a single-port SRAM macro with
//            registered BIST controls and first-fail/fail-count capture.
// Revision : 1.0  initial release
// ============================================================================
module rm_bist_march_ctrl #(
    parameter int P_ADDR_WIDTH = 10,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    A_CLK,
    input  logic                    A_RST_N,
    input  logic                    START,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    FAIL,
    output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
    output logic [7:0]              FAIL_CNT,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_M0   = 4'd1,
        S_M1   = 4'd2,
        S_M2   = 4'd3,
        S_M3   = 4'd4,
        S_M4   = 4'd5,
        S_M5   = 4'd6,
        S_CMP  = 4'd7,
        S_DONE = 4'd8
    } state_t;

    localparam logic [P_ADDR_WIDTH-1:0] c_ADDR_MAX  = {P_ADDR_WIDTH{1'b1}};
    localparam logic [P_ADDR_WIDTH-1:0] c_ADDR_ONE  = P_ADDR_WIDTH'(1);
    localparam logic [P_DATA_WIDTH-1:0] c_DATA_ONES = {P_DATA_WIDTH{1'b1}};

    state_t                  r_state;
    state_t                  w_state_nxt;
    state_t                  w_elem_nxt;
    logic [P_ADDR_WIDTH-1:0] r_addr;
    logic [P_ADDR_WIDTH-1:0] w_addr_nxt;
    logic [P_ADDR_WIDTH-1:0] w_step;
    logic                    r_phase;
    logic                    w_phase_nxt;
    logic                    w_up;
    logic                    w_last;
    logic                    w_single;
    logic                    w_start_ok;
    logic                    w_op_wr;
    logic                    w_op_rd;
    logic                    w_op_val;
    logic                    w_busy_nxt;
    logic                    w_mismatch;

    logic                    r_busy;
    logic                    r_done;
    logic                    r_en;
    logic                    r_men;
    logic                    r_wen;
    logic                    r_ren;
    logic [P_DATA_WIDTH-1:0] r_din;
    logic [P_DATA_WIDTH-1:0] r_bm;
    logic                    r_exp;
    logic                    r_chk_vld;
    logic                    r_chk_exp;
    logic [P_ADDR_WIDTH-1:0] r_chk_addr;
    logic                    r_fail;
    logic [P_ADDR_WIDTH-1:0] r_fail_addr;
    logic [7:0]              r_fail_cnt;

    assign w_up       = (r_state == S_M0) || (r_state == S_M1) || (r_state == S_M2);
    assign w_single   = (r_state == S_M0) || (r_state == S_M5);
    assign w_last     = w_up ? (r_addr == c_ADDR_MAX) : (r_addr == '0);
    assign w_step     = w_up ? (r_addr + c_ADDR_ONE) : (r_addr - c_ADDR_ONE);
    assign w_start_ok = START && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    assign w_mismatch = r_chk_vld && (A_DOUT != {P_DATA_WIDTH{r_chk_exp}});

    always_comb begin
        w_elem_nxt = S_CMP;
        case (r_state)
            S_M0:    w_elem_nxt = S_M1;
            S_M1:    w_elem_nxt = S_M2;
            S_M2:    w_elem_nxt = S_M3;
            S_M3:    w_elem_nxt = S_M4;
            S_M4:    w_elem_nxt = S_M5;
            default: w_elem_nxt = S_CMP;
        endcase
    end

    // r/w elements hold the address for the write phase; the last address of
    // an element hands over straight to the first address of the next one.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_phase_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    w_state_nxt = S_M0;
                    w_addr_nxt  = '0;
                end
            end
            S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
                if (!w_single && !r_phase) begin
                    w_phase_nxt = 1'b1;
                end else if (!w_last) begin
                    w_addr_nxt = w_step;
                end else begin
                    w_state_nxt = w_elem_nxt;
                    w_addr_nxt  = ((r_state == S_M2) || (r_state == S_M3) || (r_state == S_M4))
                                  ? c_ADDR_MAX : '0;
                end
            end
            S_CMP:   w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operation for the upcoming cycle; odd elements read 0, even read 1.
    always_comb begin
        w_op_wr  = 1'b0;
        w_op_rd  = 1'b0;
        w_op_val = 1'b0;
        case (w_state_nxt)
            S_M0: w_op_wr = 1'b1;
            S_M1, S_M2, S_M3, S_M4: begin
                w_op_wr  = w_phase_nxt;
                w_op_rd  = !w_phase_nxt;
                w_op_val = w_phase_nxt ^ ((w_state_nxt == S_M2) || (w_state_nxt == S_M4));
            end
            S_M5:    w_op_rd = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge A_CLK or negedge A_RST_N) begin
        if (!A_RST_N) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_ff @(posedge A_CLK or negedge A_RST_N) begin
        if (!A_RST_N) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_en        <= 1'b0;
            r_men       <= 1'b0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_din       <= '0;
            r_bm        <= '0;
            r_exp       <= 1'b0;
            r_chk_vld   <= 1'b0;
            r_chk_exp   <= 1'b0;
            r_chk_addr  <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_cnt  <= 8'd0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_done     <= (w_state_nxt == S_DONE);
            r_en       <= w_busy_nxt;
            r_men      <= w_op_wr || w_op_rd;
            r_wen      <= w_op_wr;
            r_ren      <= w_op_rd;
            r_din      <= (w_op_wr && w_op_val) ? c_DATA_ONES : '0;
            r_bm       <= w_op_wr ? c_DATA_ONES : '0;
            r_exp      <= w_op_val;
            // Read data arrives one cycle after the read is presented.
            r_chk_vld  <= r_ren;
            r_chk_exp  <= r_exp;
            r_chk_addr <= r_addr;
            if (w_start_ok) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_cnt  <= 8'd0;
            end else if (w_mismatch) begin
                r_fail <= 1'b1;
                if (!r_fail) begin
                    r_fail_addr <= r_chk_addr;
                end
                if (r_fail_cnt != 8'hFF) begin
                    r_fail_cnt <= r_fail_cnt + 8'd1;
                end
            end
        end
    end

    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign FAIL        = r_fail;
    assign FAIL_ADDR   = r_fail_addr;
    assign FAIL_CNT    = r_fail_cnt;
    assign A_BIST_EN   = r_en;
    assign A_BIST_MEN  = r_men;
    assign A_BIST_WEN  = r_wen;
    assign A_BIST_REN  = r_ren;
    assign A_BIST_ADDR = r_addr;
    assign A_BIST_DIN  = r_din;
    assign A_BIST_BM   = r_bm;

endmodule
`default_nettype wire

// File: tb/tb_rm_bist_march_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rm_bist_march_ctrl
// Purpose  : Bench for rm_bist_march_ctrl: March C- reference model, faulty
//            SRAM models, per-cycle op trace compare on two configurations.
// Revision : 1.0  initial release
// ============================================================================
module tb_rm_bist_march_ctrl;

    localparam int AW_B = 10;
    localparam int DW_B = 32;
    localparam int N_B  = 1024;
    localparam int AW_S = 2;
    localparam int DW_S = 8;
    localparam int N_S  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_b = 1'b1, start_b = 1'b0;
    logic            busy_b, done_b, fail_b, en_b, men_b, wen_b, ren_b;
    logic [AW_B-1:0] fail_addr_b, addr_b;
    logic [7:0]      fail_cnt_b;
    logic [DW_B-1:0] din_b, bm_b, dout_b;

    logic            rst_s = 1'b1, start_s = 1'b0;
    logic            busy_s, done_s, fail_s, en_s, men_s, wen_s, ren_s;
    logic [AW_S-1:0] fail_addr_s, addr_s;
    logic [7:0]      fail_cnt_s;
    logic [DW_S-1:0] din_s, bm_s, dout_s;

    rm_bist_march_ctrl #(.P_ADDR_WIDTH(AW_B), .P_DATA_WIDTH(DW_B)) dut_b (
        .A_CLK(clk), .A_RST_N(rst_b), .START(start_b), .BUSY(busy_b), .DONE(done_b),
        .FAIL(fail_b), .FAIL_ADDR(fail_addr_b), .FAIL_CNT(fail_cnt_b),
        .A_BIST_EN(en_b), .A_BIST_MEN(men_b), .A_BIST_WEN(wen_b), .A_BIST_REN(ren_b),
        .A_BIST_ADDR(addr_b), .A_BIST_DIN(din_b), .A_BIST_BM(bm_b), .A_DOUT(dout_b));

    rm_bist_march_ctrl #(.P_ADDR_WIDTH(AW_S), .P_DATA_WIDTH(DW_S)) dut_s (
        .A_CLK(clk), .A_RST_N(rst_s), .START(start_s), .BUSY(busy_s), .DONE(done_s),
        .FAIL(fail_s), .FAIL_ADDR(fail_addr_s), .FAIL_CNT(fail_cnt_s),
        .A_BIST_EN(en_s), .A_BIST_MEN(men_s), .A_BIST_WEN(wen_s), .A_BIST_REN(ren_s),
        .A_BIST_ADDR(addr_s), .A_BIST_DIN(din_s), .A_BIST_BM(bm_s), .A_DOUT(dout_s));

    int n_chk = 0;
    int n_pass = 0;
    bit mon_on = 1'b0;
    // fault modes: 0 none, 1 stuck bit (fb at fa, polarity fs), 2 no writes + reads all-ones
    int mode_b = 0, fa_b = 0, fb_b = 0, fs_b = 0;
    int mode_s = 0, fa_s = 0, fb_s = 0, fs_s = 0;
    logic [31:0] mem_b [N_B];
    logic [31:0] mem_s [N_S];

    function automatic logic [31:0] ones_of(input int dw);
        return (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    endfunction

    // Operation number idx of a March C- run on n words.
    function automatic void exp_op(input int n, input int idx, output bit wr, output int a, output bit v);
        int k, e, j, pos;
        if (idx < n) begin
            wr = 1'b1; a = idx; v = 1'b0;
        end else begin
            k = idx - n;
            if (k < 8 * n) begin
                e   = k / (2 * n) + 1;
                j   = k % (2 * n);
                pos = j / 2;
                a   = (e <= 2) ? pos : (n - 1 - pos);
                wr  = (j % 2) == 1;
                v   = wr ^ ((e == 2) || (e == 4));
            end else begin
                k  = k - 8 * n;
                wr = 1'b0; a = n - 1 - k; v = 1'b0;
            end
        end
    endfunction

    function automatic logic [31:0] flt_rd(input int mode, input int dw, input int a, input logic [31:0] d,
                                           input int fa, input int fb, input int fs);
        logic [31:0] r;
        r = d;
        if (mode == 2) r = 32'hFFFF_FFFF;
        else if (mode == 1 && a == fa) r = (fs != 0) ? (d | (32'd1 << fb)) : (d & ~(32'd1 << fb));
        return r & ones_of(dw);
    endfunction

    function automatic void predict(input int n, input int dw, input int mode, input int fa, input int fb,
                                    input int fs, output bit f, output int fad, output int cnt);
        logic [31:0] m [];
        logic [31:0] rd;
        bit wr, v;
        int a;
        m = new[n];
        f = 1'b0; fad = 0; cnt = 0;
        for (int i = 0; i < 10 * n; i++) begin
            exp_op(n, i, wr, a, v);
            if (wr) begin
                if (mode != 2) m[a] = v ? ones_of(dw) : 32'h0;
            end else begin
                rd = flt_rd(mode, dw, a, m[a], fa, fb, fs);
                if (rd != (v ? ones_of(dw) : 32'h0)) begin
                    if (!f) fad = a;
                    f = 1'b1;
                    cnt = (cnt < 255) ? cnt + 1 : 255;
                end
            end
        end
    endfunction

    function automatic bit cyc_ok(input int n, input int dw, input int idx, input bit busy, input bit done,
                                  input bit en, input bit men, input bit wen, input bit ren, input int addr,
                                  input logic [31:0] din, input logic [31:0] bm);
        bit ewr, ev;
        int ea;
        if (!busy) return !(en || men || wen || ren) && addr == 0 && din == 32'h0 && bm == 32'h0;
        if (done || !en || idx > 10 * n) return 1'b0;
        if (idx == 10 * n) return !(men || wen || ren) && bm == 32'h0;
        exp_op(n, idx, ewr, ea, ev);
        if (!men || wen != ewr || ren == ewr || addr != ea) return 1'b0;
        if (ewr) return din == (ev ? ones_of(dw) : 32'h0) && bm == ones_of(dw);
        return bm == 32'h0;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic cyc_chk(input string nm, input int n, input int dw, input int idx, input bit busy,
                           input bit done, input bit en, input bit men, input bit wen, input bit ren,
                           input int addr, input logic [31:0] din, input logic [31:0] bm);
        bit ewr, ev;
        int ea;
        n_chk++;
        if (cyc_ok(n, dw, idx, busy, done, en, men, wen, ren, addr, din, bm)) begin
            n_pass++;
        end else begin
            exp_op(n, idx, ewr, ea, ev);
            $display("FAIL %s idx=%0d: got busy=%b done=%b en=%b men=%b wen=%b ren=%b addr=%0h din=%0h bm=%0h; expected op wr=%b addr=%0h val=%b (no op when idle or at idx %0d)",
                     nm, idx, busy, done, en, men, wen, ren, addr, din, bm, ewr, ea, ev, 10 * n);
        end
    endtask

    // Behavioural SRAMs: synchronous read, masked write.
    always @(posedge clk) begin
        if (men_b && wen_b && mode_b != 2) mem_b[addr_b] <= (mem_b[addr_b] & ~bm_b) | (din_b & bm_b);
        if (men_b && ren_b) dout_b <= flt_rd(mode_b, DW_B, int'(addr_b), mem_b[addr_b], fa_b, fb_b, fs_b);
    end
    always @(posedge clk) begin
        if (men_s && wen_s && mode_s != 2)
            mem_s[addr_s] <= (mem_s[addr_s] & ~{24'h0, bm_s}) | ({24'h0, din_s} & {24'h0, bm_s});
        if (men_s && ren_s) dout_s <= 8'(flt_rd(mode_s, DW_S, int'(addr_s), mem_s[addr_s], fa_s, fb_s, fs_s));
    end

    int idx_b = 0, len_b = 0, idx_s = 0, len_s = 0;
    bit wb_b = 1'b0, wb_s = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (busy_b && !wb_b) idx_b = 0;
            cyc_chk("cycle_b", N_B, DW_B, idx_b, busy_b, done_b, en_b, men_b, wen_b, ren_b,
                    int'(addr_b), din_b, bm_b);
            if (wb_b && !busy_b) begin
                len_b = idx_b;
                if (idx_b == 10 * N_B + 1) chk("done_rise_b", done_b, 1);
            end
            if (busy_b) idx_b++;
            wb_b = busy_b;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (busy_s && !wb_s) idx_s = 0;
            cyc_chk("cycle_s", N_S, DW_S, idx_s, busy_s, done_s, en_s, men_s, wen_s, ren_s,
                    int'(addr_s), {24'h0, din_s}, {24'h0, bm_s});
            if (wb_s && !busy_s) begin
                len_s = idx_s;
                if (idx_s == 10 * N_S + 1) chk("done_rise_s", done_s, 1);
            end
            if (busy_s) idx_s++;
            wb_s = busy_s;
        end
    end

    task automatic pulse_b();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
    endtask

    task automatic pulse_s();
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
    endtask

    task automatic wait_done_b(input string nm);
        int c = 0;
        while (!done_b && c < 10 * N_B + 50) begin @(negedge clk); c++; end
        chk({nm, "_done_reached"}, done_b, 1);
        #1;
    endtask

    task automatic wait_done_s(input string nm);
        int c = 0;
        while (!done_s && c < 10 * N_S + 50) begin @(negedge clk); c++; end
        chk({nm, "_done_reached"}, done_s, 1);
        #1;
    endtask

    task automatic run_b(input string nm, input int mode, input int fa, input int fb, input int fs,
                         output bit pf, output int pa, output int pc);
        mode_b = mode; fa_b = fa; fb_b = fb; fs_b = fs;
        predict(N_B, DW_B, mode, fa, fb, fs, pf, pa, pc);
        pulse_b();
        chk({nm, "_busy_at_start"}, busy_b, 1);
        chk({nm, "_done_cleared"}, done_b, 0);
        wait_done_b(nm);
        chk({nm, "_busy_len"}, len_b, 10 * N_B + 1);
        chk({nm, "_busy_low"}, busy_b, 0);
        chk({nm, "_fail"}, fail_b, pf);
        chk({nm, "_fail_addr"}, fail_addr_b, pa);
        chk({nm, "_fail_cnt"}, fail_cnt_b, pc);
    endtask

    task automatic run_s(input string nm, input int mode, input int fa, input int fb, input int fs);
        bit pf;
        int pa, pc;
        mode_s = mode; fa_s = fa; fb_s = fb; fs_s = fs;
        predict(N_S, DW_S, mode, fa, fb, fs, pf, pa, pc);
        pulse_s();
        chk({nm, "_busy_at_start"}, busy_s, 1);
        wait_done_s(nm);
        chk({nm, "_busy_len"}, len_s, 10 * N_S + 1);
        chk({nm, "_fail"}, fail_s, pf);
        chk({nm, "_fail_addr"}, fail_addr_s, pa);
        chk({nm, "_fail_cnt"}, fail_cnt_s, pc);
    endtask

    initial begin
        bit pf, ewr, ev;
        int pa, pc, ea;
        for (int i = 0; i < N_B; i++) mem_b[i] = $urandom;
        for (int i = 0; i < N_S; i++) mem_s[i] = $urandom;
        #2 rst_b = 1'b0; rst_s = 1'b0;
        #1 mon_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_b", int'(|{busy_b, done_b, fail_b, fail_addr_b, fail_cnt_b, en_b, men_b,
                                      wen_b, ren_b, addr_b, din_b, bm_b}), 0);
        chk("reset_outputs_s", int'(|{busy_s, done_s, fail_s, fail_addr_s, fail_cnt_s, en_s, men_s,
                                      wen_s, ren_s, addr_s, din_s, bm_s}), 0);
        @(negedge clk); rst_b = 1'b1; rst_s = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("idle_after_reset_b", busy_b, 0);

        // Pin the model with hand-derived points.
        exp_op(4, 4, ewr, ea, ev);
        chk("model_n4_i4", {ewr, ea[7:0], ev}, {1'b0, 8'd0, 1'b0});
        exp_op(4, 27, ewr, ea, ev);
        chk("model_n4_i27", {ewr, ea[7:0], ev}, {1'b1, 8'd0, 1'b1});
        exp_op(1024, 10239, ewr, ea, ev);
        chk("model_n1024_last", {ewr, ea[15:0], ev}, {1'b0, 16'd0, 1'b0});

        run_b("clean_b", 0, 0, 0, 0, pf, pa, pc);
        chk("clean_b_cnt_lit", fail_cnt_b, 0);

        run_b("sa1_155", 1, 'h155, 3, 1, pf, pa, pc);
        chk("model_sa1_cnt", pc, 3);
        chk("sa1_155_addr_lit", fail_addr_b, 'h155);
        chk("sa1_155_cnt_lit", fail_cnt_b, 3);

        run_b("nowrite", 2, 0, 0, 0, pf, pa, pc);
        chk("nowrite_addr_lit", fail_addr_b, 0);
        chk("nowrite_cnt_lit", fail_cnt_b, 255);

        run_b("rand_big", 1, int'($urandom_range(0, N_B - 1)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 1)), pf, pa, pc);

        // Asynchronous reset in the middle of M2.
        mode_b = 1; fa_b = 5; fb_b = 0; fs_b = 1;
        pulse_b();
        repeat (4000) @(posedge clk);
        #1 chk("pre_reset_fail", fail_b, 1);
        #1 rst_b = 1'b0;
        #1 chk("midrun_reset_zero", int'(|{busy_b, done_b, fail_b, fail_addr_b, fail_cnt_b, en_b, men_b,
                                             wen_b, ren_b, addr_b, din_b, bm_b}), 0);
        @(negedge clk); rst_b = 1'b1;
        repeat (50) @(posedge clk);
        #1 chk("no_op_after_reset", int'(|{busy_b, men_b, done_b}), 0);

        // START held through a whole run, then the automatic restart from DONE.
        mode_b = 1; fa_b = 'h2A; fb_b = 0; fs_b = 1;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 chk("held_busy", busy_b, 1);
        wait_done_b("held_run1");
        chk("held_run1_len", len_b, 10 * N_B + 1);
        chk("held_run1_fail", fail_b, 1);
        chk("held_run1_cnt", fail_cnt_b, 3);
        mode_b = 0;
        @(posedge clk); #1;
        chk("restart_busy", busy_b, 1);
        chk("restart_done_clr", done_b, 0);
        chk("restart_fail_clr", fail_b, 0);
        chk("restart_cnt_clr", fail_cnt_b, 0);
        chk("restart_addr_clr", fail_addr_b, 0);
        start_b = 1'b0;
        wait_done_b("held_run2");
        chk("held_run2_len", len_b, 10 * N_B + 1);
        chk("held_run2_fail", fail_b, 0);

        // Small configuration: exact trace, then randomized faults and resets.
        run_s("trace_s", 0, 0, 0, 0);
        for (int it = 0; it < 24; it++) begin
            int m, fa, fb, fs;
            m  = int'($urandom_range(0, 2));
            fa = int'($urandom_range(0, N_S - 1));
            fb = int'($urandom_range(0, DW_S - 1));
            fs = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 4)) @(posedge clk);
            if ($urandom_range(0, 4) == 0) begin
                mode_s = m; fa_s = fa; fb_s = fb; fs_s = fs;
                pulse_s();
                repeat ($urandom_range(1, 38)) @(posedge clk);
                #2 rst_s = 1'b0;
                #1 chk("rand_reset_zero_s", int'(|{busy_s, done_s, fail_s, fail_addr_s, fail_cnt_s, en_s,
                                                    men_s, wen_s, ren_s, addr_s, din_s, bm_s}), 0);
                @(negedge clk); rst_s = 1'b1;
            end else begin
                run_s($sformatf("rand_s%0d", it), m, fa, fb, fs);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
